// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the hazard control unit: FSM states, bubble
// instruction and the debug stall-cause codes.
package hazard_control_unit_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MD_WAIT = 2'd1;
  localparam logic [1:0] ST_MD_DONE = 2'd2;

  // addi x0, x0, 0 -- what a flushed pipeline register holds
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_RESET    = 3'd1;
  localparam logic [2:0] CAUSE_MEM      = 3'd2;
  localparam logic [2:0] CAUSE_MD       = 3'd3;
  localparam logic [2:0] CAUSE_BRANCH   = 3'd4;
  localparam logic [2:0] CAUSE_LOAD_USE = 3'd5;

  function automatic logic load_use_hit(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       rs1_used,
    input logic       rs2_used,
    input logic [4:0] rd,
    input logic       mem_read
  );
    // x0 is never a real dependency
    return mem_read && (rd != 5'd0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; clr restarts it.
module hazard_control_unit_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: memory/mul-div stalls, branch flushes,
// load-use bubbles, plus saturating stall and flush counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_md_op,
  input  logic                 ex_branch_taken,
  input  logic                 md_done,
  input  logic                 dmem_req,
  input  logic                 dmem_ack,
  output logic                 md_start,
  output logic                 pc_we,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 md_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [1:0]           dbg_state,
  output logic [2:0]           dbg_cause
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic          mem_stall, md_busy, load_use, flush_inc;
  logic [TW-1:0] tmo_count;

  assign mem_stall = dmem_req & ~dmem_ack;
  assign md_busy   = (state_q == ST_MD_WAIT) | ((state_q == ST_RUN) & ex_md_op);
  assign load_use  = load_use_hit(id_rs1, id_rs2, id_rs1_used, id_rs2_used,
                                  ex_rd, ex_mem_read);

  // Highest-priority condition wins; reset fills every register with bubbles.
  always_comb begin
    pc_we        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_start     = 1'b0;
    flush_inc    = 1'b0;
    dbg_cause    = CAUSE_NONE;
    if (rst) begin
      pc_we        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      dbg_cause    = CAUSE_RESET;
    end else if (mem_stall) begin
      pc_we     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      dbg_cause = CAUSE_MEM;
    end else if (md_busy) begin
      pc_we        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      md_start     = (state_q == ST_RUN);
      dbg_cause    = CAUSE_MD;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc   = 1'b1;
      dbg_cause   = CAUSE_BRANCH;
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      dbg_cause   = CAUSE_LOAD_USE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (md_start)  state_d = ST_MD_WAIT;
      ST_MD_WAIT: if (md_done)   state_d = ST_MD_DONE;
      ST_MD_DONE: if (ex_mem_en) state_d = ST_RUN;
      default:                   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = state_q;

  hazard_control_unit_sat_counter #(.WIDTH(TW)) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (md_start),
    .inc   (state_q == ST_MD_WAIT),
    .count (tmo_count)
  );

  // Sticky: set on the edge where the wait count reaches MD_TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_timeout <= 1'b0;
    end else if ((state_q == ST_MD_WAIT) && (tmo_count == TW'(MD_TIMEOUT - 1))) begin
      md_timeout <= 1'b1;
    end
  end

  hazard_control_unit_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (~pc_we & ~rst),
    .count (stall_cycles)
  );

  hazard_control_unit_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; a second 4-bit-counter instance
// covers counter saturation.
module tb_hazard_control_unit;

  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2;
  // ctl = {pc_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush}
  localparam logic [7:0] C_RESET = 8'h7F, C_NORM = 8'hF8, C_MEM = 8'h00;
  localparam logic [7:0] C_MD = 8'h19, C_BR = 8'hFE, C_LU = 8'h3A;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_md_op, ex_branch_taken;
  logic md_done, dmem_req, dmem_ack;

  logic md_start, pc_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, md_timeout;
  logic [31:0] stall_cycles, flush_count;
  logic [1:0] dbg_state;
  logic [2:0] dbg_cause;

  logic md_start4, pc_we4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
  logic if_id_flush4, id_ex_flush4, ex_mem_flush4, md_timeout4;
  logic [3:0] stall_cycles4, flush_count4;
  logic [1:0] dbg_state4;
  logic [2:0] dbg_cause4;

  logic [7:0] ctl;
  assign ctl = {pc_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_control_unit u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_md_op(ex_md_op), .ex_branch_taken(ex_branch_taken),
    .md_done(md_done), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .md_start(md_start), .pc_we(pc_we), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .md_timeout(md_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .dbg_state(dbg_state), .dbg_cause(dbg_cause)
  );

  hazard_control_unit #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_md_op(ex_md_op), .ex_branch_taken(ex_branch_taken),
    .md_done(md_done), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .md_start(md_start4), .pc_we(pc_we4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4),
    .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4), .if_id_flush(if_id_flush4),
    .id_ex_flush(id_ex_flush4), .ex_mem_flush(ex_mem_flush4), .md_timeout(md_timeout4),
    .stall_cycles(stall_cycles4), .flush_count(flush_count4),
    .dbg_state(dbg_state4), .dbg_cause(dbg_cause4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_md_op = 1'b0; ex_branch_taken = 1'b0;
    md_done = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    tick();
    n_cmp++; if (ctl !== C_RESET) begin n_err++; $display("FAIL reset_ctl: got %h expected %h", ctl, C_RESET); end
    n_cmp++; if (md_start !== 1'b0) begin n_err++; $display("FAIL reset_md_start: got %b expected 0", md_start); end
    n_cmp++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count); end
    n_cmp++; if (dbg_state !== S_RUN || md_timeout !== 1'b0) begin n_err++; $display("FAIL reset_state: got state %0d tmo %b expected 0/0", dbg_state, md_timeout); end
    rst = 1'b0;
    #1;
    n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL post_reset_ctl: got %h expected %h", ctl, C_NORM); end
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1;
    n_cmp++; if (ctl !== C_LU) begin n_err++; $display("FAIL load_use_ctl: got %h expected %h", ctl, C_LU); end
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL load_use_release: got %h expected %h", ctl, C_NORM); end
    n_cmp++; if (stall_cycles !== 32'd1) begin n_err++; $display("FAIL load_use_stalls: got %0d expected 1", stall_cycles); end
    // rs2-only dependency also counts
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd1; id_rs2 = 5'd9; id_rs2_used = 1'b1;
    #1;
    n_cmp++; if (ctl !== C_LU) begin n_err++; $display("FAIL load_use_rs2: got %h expected %h", ctl, C_LU); end
    set_idle();
  endtask

  task automatic test_load_use_neg();
    apply_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1;
    n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL lu_neg_x0: got %h expected %h", ctl, C_NORM); end
    ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5; id_rs2_used = 1'b0;
    #1;
    n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL lu_neg_rs2_unused: got %h expected %h", ctl, C_NORM); end
    ex_mem_read = 1'b0; id_rs1 = 5'd5;
    #1;
    n_cmp++; if (ctl !== C_NORM) begin n_err++; $display("FAIL lu_neg_not_load: got %h expected %h", ctl, C_NORM); end
    tick();
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL lu_neg_stalls: got %0d expected 0", stall_cycles); end
    set_idle();
  endtask

  task automatic test_branch();
    apply_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1; ex_branch_taken = 1'b1;
    #1;
    n_cmp++; if (ctl !== C_BR) begin n_err++; $display("FAIL branch_ctl: got %h expected %h", ctl, C_BR); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (flush_count !== 32'd1 || stall_cycles !== 32'd0) begin n_err++; $display("FAIL branch_counts: got %0d/%0d expected 1/0", flush_count, stall_cycles); end
  endtask

  task automatic test_muldiv();
    int starts;
    starts = 0;
    apply_reset();
    ex_md_op = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      md_done = (c == 10);
      #1;
      if (md_start === 1'b1) starts++;
      n_cmp++; if (ctl !== C_MD || md_start !== (c == 0)) begin n_err++; $display("FAIL md_busy_c%0d: got ctl %h start %b expected %h %b", c, ctl, md_start, C_MD, (c == 0)); end
      tick();
    end
    md_done = 1'b0;
    #1;
    n_cmp++; if (starts != 1) begin n_err++; $display("FAIL md_start_pulses: got %0d expected 1", starts); end
    n_cmp++; if (dbg_state !== S_DONE || ctl !== C_NORM || md_start !== 1'b0) begin n_err++; $display("FAIL md_done_state: got state %0d ctl %h start %b expected 2 %h 0", dbg_state, ctl, md_start, C_NORM); end
    tick();
    ex_md_op = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== S_RUN || stall_cycles !== 32'd11) begin n_err++; $display("FAIL md_finish: got state %0d stalls %0d expected 0 11", dbg_state, stall_cycles); end
    // a stray md_done in RUN must not move the FSM
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== S_RUN) begin n_err++; $display("FAIL md_done_ignored: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_md_mem_stall();
    apply_reset();
    ex_md_op = 1'b1; dmem_req = 1'b1;
    #1;
    n_cmp++; if (md_start !== 1'b0 || ctl !== C_MEM) begin n_err++; $display("FAIL md_defer: got start %b ctl %h expected 0 %h", md_start, ctl, C_MEM); end
    tick();
    dmem_req = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== S_RUN || md_start !== 1'b1) begin n_err++; $display("FAIL md_deferred_start: got state %0d start %b expected 0 1", dbg_state, md_start); end
    tick();
    tick();
    dmem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      md_done = (c == 1);
      #1;
      n_cmp++; if (ctl !== C_MEM || md_start !== 1'b0) begin n_err++; $display("FAIL md_memstall_c%0d: got ctl %h start %b expected %h 0", c, ctl, md_start, C_MEM); end
      tick();
    end
    md_done = 1'b0;
    n_cmp++; if (dbg_state !== S_DONE) begin n_err++; $display("FAIL md_memstall_hold: got %0d expected 2", dbg_state); end
    dmem_ack = 1'b1;
    #1;
    n_cmp++; if (ex_mem_en !== 1'b1 || md_start !== 1'b0 || pc_we !== 1'b1) begin n_err++; $display("FAIL md_memstall_release: got en %b start %b pc %b expected 1 0 1", ex_mem_en, md_start, pc_we); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (dbg_state !== S_RUN) begin n_err++; $display("FAIL md_memstall_run: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_timeout_reset();
    apply_reset();
    ex_md_op = 1'b1;
    tick();
    for (int c = 0; c < 63; c++) tick();
    n_cmp++; if (md_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b expected 0", md_timeout); end
    tick();
    n_cmp++; if (md_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b expected 1", md_timeout); end
    for (int c = 0; c < 5; c++) tick();
    n_cmp++; if (md_timeout !== 1'b1 || dbg_state !== S_WAIT) begin n_err++; $display("FAIL timeout_sticky: got %b state %0d expected 1 1", md_timeout, dbg_state); end
    set_idle();
    rst = 1'b1;
    #1;
    n_cmp++; if (md_start !== 1'b0 || ctl !== C_RESET) begin n_err++; $display("FAIL timeout_rst_comb: got start %b ctl %h expected 0 %h", md_start, ctl, C_RESET); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (md_timeout !== 1'b0 || stall_cycles !== 32'd0 || dbg_state !== S_RUN || md_start !== 1'b0) begin n_err++; $display("FAIL timeout_rst: got tmo %b stalls %0d state %0d start %b expected 0 0 0 0", md_timeout, stall_cycles, dbg_state, md_start); end
  endtask

  task automatic test_saturation();
    apply_reset();
    dmem_req = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    set_idle();
    #1;
    n_cmp++; if (stall_cycles4 !== 4'd15) begin n_err++; $display("FAIL sat_stall4: got %0d expected 15", stall_cycles4); end
    n_cmp++; if (stall_cycles !== 32'd20) begin n_err++; $display("FAIL sat_stall32: got %0d expected 20", stall_cycles); end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_load_use_neg();
    test_branch();
    test_muldiv();
    test_md_mem_stall();
    test_timeout_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencing controller for the 5-stage core; it sits beside the operand forwarding unit and handles the hazards forwarding cannot resolve.
- Detects load-use hazards.
- Stalls on data-memory wait and on the multi-cycle mul/div unit.
- Flushes wrong-path instructions on taken branches/jumps.
- Drives every pipeline-register enable/flush and the PC write enable, and keeps saturating stall/flush performance counters.

Parameters:
CNT_WIDTH, 32, width of each performance counter
MD_TIMEOUT, 64, max cycles in MD_WAIT before md_timeout asserts

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_md_op  in  1  EX instruction is mul/div
ex_branch_taken  in  1  EX resolved taken branch/jump
md_done  in  1  mul/div result ready, 1-cycle pulse; unit holds result until next md_start
dmem_req  in  1  MEM stage has an outstanding data access
dmem_ack  in  1  data memory completes access
md_start  out  1  1-cycle start pulse to mul/div unit
pc_we  out  1  PC write enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load bubble (NOP) into register
md_timeout  out  1  sticky error, mul/div exceeded MD_TIMEOUT
stall_cycles  out  CNT_WIDTH  cycles with pc_we=0
flush_count  out  CNT_WIDTH  taken-branch flushes

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.

FSM states: RUN, MD_WAIT, MD_DONE.

Stall priority, evaluated combinationally each cycle:
1. Memory stall: dmem_req & !dmem_ack → all enables 0, all flushes 0, pc_we=0. Overrides everything, including branch.
2. Mul/div busy: state MD_WAIT, or RUN with ex_md_op → pc_we, if_id_en, id_ex_en = 0; ex_mem_en=1 with ex_mem_flush=1 (bubble into MEM); mem_wb_en=1.
3. Taken branch: ex_branch_taken → pc_we=1, all enables 1, if_id_flush=1, id_ex_flush=1; flush_count += 1.
4. Load-use: ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)) → pc_we=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1. Exactly one bubble per hazard.
5. Otherwise: all enables 1, flushes 0.
- Branch beats load-use: the ID instruction is wrong-path.

FSM transitions:
- RUN & ex_md_op & no memory stall → md_start=1 for one cycle, go to MD_WAIT, clear timeout counter. Under a memory stall, md_start is deferred until the stall releases.
- MD_WAIT: timeout counter increments each cycle. md_done → MD_DONE.
  - Counter reaching MD_TIMEOUT sets md_timeout (cleared only by rst); the FSM keeps waiting.
- MD_DONE: the EX instruction carries its result and is treated as a normal instruction (priorities 1, 3, 4, 5 apply).
  - When ex_mem_en=1 → RUN. Under a memory stall, stay in MD_DONE; never re-issue md_start.
- md_done outside MD_WAIT is ignored.
- ex_branch_taken while in MD_WAIT is ignored; it cannot occur, since a md op is not a branch.

Counters:
- stall_cycles increments whenever pc_we=0 and not rst.
- Both counters saturate at all-ones; no wrap.

Reset:
- While rst=1: state RUN; counters 0; md_timeout=0; md_start=0; pc_we=0; all enables 1; all flushes 1. The pipe fills with bubbles.
- Reset mid-MD_WAIT abandons the op; md_start stays 0 the cycle after reset.

Latency: md_start asserts in the first cycle the op sits in EX; the result advances the cycle after md_done at the earliest.

Decomposition:
- Shared package: FSM state encodings, NOP/bubble constant, stall-cause codes for debug.
- Natural sub-module: sat_counter (parameterised width, inc, rst), instantiated for stall_cycles, flush_count and the MD timeout counter.

Test Plan:
- Load-use: EX lw x5 (ex_mem_read=1, ex_rd=5), ID add rs1=5 used → exactly one cycle pc_we=0, id_ex_flush=1, stall_cycles=1; next cycle all enables 1.
- Load-use negatives: ex_rd=0, or rs2=5 with id_rs2_used=0 → no stall.
- Branch flush with simultaneous load-use: ex_branch_taken=1 with hazard conditions true → if_id_flush=id_ex_flush=1, pc_we=1, flush_count=1.
- Mul/div: ex_md_op=1, md_done after 10 cycles → md_start exactly once in cycle 0, pc_we=0 and ex_mem_flush=1 for 11 cycles, then RUN, stall_cycles=11.
- md_done during memory stall: dmem_req=1, dmem_ack=0 held 3 cycles around md_done → state MD_DONE held, all enables 0, no second md_start; release → ex_mem_en=1, state RUN.
- Timeout and reset: md_done withheld 64 cycles → md_timeout=1 and sticky. Assert rst → md_timeout=0, counters 0, state RUN, md_start=0.
- Saturation: with CNT_WIDTH=4, stall 20 cycles → stall_cycles holds 15.
